// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU operation encodings and result arithmetic
package mdu_pkg;

  localparam int MDU_OP_W = 3;
  localparam int CNT_W    = 16;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef struct packed {
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  // INT_MIN / -1 is pinned explicitly so no tool has to define signed overflow.
  function automatic mdu_res_t mdu_compute(input mdu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    mdu_res_t    res;
    logic [63:0] prod;
    res  = '0;
    prod = '0;
    case (op)
      MDU_MULT: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MDU_MULTU: begin
        prod   = {32'd0, a} * {32'd0, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MDU_DIV: begin
        if (b == 32'd0) begin
          res.div0 = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res.lo = 32'h8000_0000;
        end else begin
          res.lo = $signed(a) / $signed(b);
          res.hi = $signed(a) % $signed(b);
        end
      end
      MDU_DIVU: begin
        if (b == 32'd0) begin
          res.div0 = 1'b1;
        end else begin
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit holding HI/LO
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] MDUop,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                busy,
  output logic [31:0]         HI,
  output logic [31:0]         LO
);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             div0_q, div0_d;
  mdu_op_e          op;
  mdu_res_t         res;

  assign op  = mdu_op_e'(MDUop);
  assign res = mdu_compute(op, A, B);

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    div0_d   = div0_q;
    if (busy_q) begin
      // Result is committed on the last busy edge; a zero divisor leaves HI/LO alone.
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (!div0_q) begin
          hi_d = hi_tmp_q;
          lo_d = lo_tmp_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          hi_tmp_d = res.hi;
          lo_tmp_d = res.lo;
          div0_d   = 1'b0;
          cnt_d    = CNT_W'(MULT_CYCLES);
          busy_d   = 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          hi_tmp_d = res.hi;
          lo_tmp_d = res.lo;
          div0_d   = res.div0;
          cnt_d    = CNT_W'(DIV_CYCLES);
          busy_d   = 1'b1;
        end
        MDU_MTHI: hi_d = A;
        MDU_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
